mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
- Parametrised MEM→WB pipeline register carrying NUM_CH independent write-back channels (e.g. ch0 = GPR, ch1 = HI/LO).
- Adds the following to the plain MEM/WB latch:
  - stall hold and flush;
  - bubble insertion when MEM stalls while WB proceeds;
  - a valid bit;
  - zero-register write suppression;
  - same-address write arbitration across channels;
  - a saturating bubble/flush counter for performance monitoring.
- Sits between the MEM stage and the register-file write ports.

Parameters:
- DATA_W, 32, data width per channel.
- ADDR_W, 5, register address width per channel.
- NUM_CH, 2, number of write-back channels (1..4).
- ZERO_SUPPRESS, 1, when 1, a channel-0 write to address 0 is dropped (we forced to 0).
- SHARED_SPACE, 0, when 1, all channels address the same register file and same-address collisions are arbitrated.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_mem  in  1  MEM stage stalled this cycle.
- stall_wb  in  1  WB stage stalled this cycle.
- flush  in  1  discard the MEM-stage contents (exception/redirect).
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_wdata  in  NUM_CH*DATA_W  channel write data; ch k in bits [k*DATA_W +: DATA_W].
- mem_waddr  in  NUM_CH*ADDR_W  channel write addresses, packed the same way.
- mem_we  in  NUM_CH  channel write enables.
- wb_wdata  out  NUM_CH*DATA_W  registered write data.
- wb_waddr  out  NUM_CH*ADDR_W  registered write addresses.
- wb_we  out  NUM_CH  registered write enables.
- wb_valid  out  1  WB holds a real instruction.
- bubble_cnt  out  CNT_W  saturating count of bubbles plus flushes.

Behaviour:
- Reset value of all outputs is 0 (wb_wdata, wb_waddr, wb_we, wb_valid, bubble_cnt).
- Latency is 1 cycle MEM→WB. There is no combinational input→output path.
- Per rising edge, first matching rule wins:
  1. rst=1 → all registers 0.
  2. flush=1 → load a bubble (wdata=0, waddr=0, we=0, valid=0); bubble_cnt+1.
  3. stall_wb=1 → hold all registers (stall_wb dominates stall_mem).
  4. stall_mem=1 and stall_wb=0 → load a bubble; bubble_cnt+1.
  5. Otherwise → load: wdata/waddr copied; valid=mem_valid; we[k]=mem_we[k] & mem_valid & ~suppress[k] & ~lose[k].
- Flush overrides stall_wb: a flushed cycle never holds old contents.
- suppress[0] = ZERO_SUPPRESS & (mem_waddr ch0 == 0). suppress[k] = 0 for k>0.
- lose[k] applies only when SHARED_SPACE=1: lose[k]=1 if some j>k has effective mem_we[j]=1 and the same address. The highest-index channel wins.
- When SHARED_SPACE=0, lose is always 0.
- Data and address are loaded even when the corresponding we=0. Downstream must qualify with we.
- bubble_cnt saturates at all-ones and never wraps. Hold cycles do not increment it.
- mem_valid=0 in a load cycle is not counted as a bubble. It yields wb_valid=0 and all we=0.
- A hold keeps a bubble a bubble. No data from MEM leaks in during the hold.
- Reset asserted mid-stall clears everything on the next edge.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs nonzero → all outputs 0. The cycle after release with mem_valid=1, ch0 we=1/addr=3/data=0xDEADBEEF → wb matches on the next edge.
- Pass-through: stream 5 instrs ch0 addr=1..5, data=0x10..0x50, ch1 we=1 data=0xA5 → each appears exactly one cycle later; bubble_cnt=0.
- Stall bubble: stall_mem=1, stall_wb=0 for 3 cycles → wb_we=0, wb_valid=0 for 3 cycles, bubble_cnt=3. Then stall_wb=1 with stall_mem=1 for 2 cycles → outputs frozen, bubble_cnt stays 3.
- Flush: flush=1 together with stall_wb=1 and a valid input → next cycle wb_valid=0, all we=0, bubble_cnt+1.
- Zero/collision: ch0 we=1 addr=0 → wb_we[0]=0. With SHARED_SPACE=1, ch0 and ch1 both write addr 7 → wb_we=2'b10.
- Saturation: CNT_W=3, 10 consecutive bubbles → bubble_cnt stops at 7.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register for NUM_CH write-back channels with stall hold,
// flush/bubble insertion, zero-register suppression, same-address arbitration and a bubble counter.
module mem_wb_pipe #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int NUM_CH        = 2,
    parameter int ZERO_SUPPRESS = 1,
    parameter int SHARED_SPACE  = 0,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_mem,
    input  logic                       stall_wb,
    input  logic                       flush,
    input  logic                       mem_valid,
    input  logic [NUM_CH*DATA_W-1:0]   mem_wdata,
    input  logic [NUM_CH*ADDR_W-1:0]   mem_waddr,
    input  logic [NUM_CH-1:0]          mem_we,
    output logic [NUM_CH*DATA_W-1:0]   wb_wdata,
    output logic [NUM_CH*ADDR_W-1:0]   wb_waddr,
    output logic [NUM_CH-1:0]          wb_we,
    output logic                       wb_valid,
    output logic [CNT_W-1:0]           bubble_cnt
);

    logic [NUM_CH*DATA_W-1:0] wdata_q, wdata_d;
    logic [NUM_CH*ADDR_W-1:0] waddr_q, waddr_d;
    logic [NUM_CH-1:0]        we_q, we_d;
    logic                     valid_q, valid_d;
    logic [CNT_W-1:0]         bubble_cnt_q, bubble_cnt_d;

    logic [NUM_CH-1:0]        suppress_s;
    logic [NUM_CH-1:0]        cand_s;
    logic [NUM_CH-1:0]        lose_s;
    logic [NUM_CH-1:0]        load_we_s;
    logic [CNT_W-1:0]         cnt_inc_s;

    // Qualify channel write enables: drop ch0 writes to r0, then let the highest channel win a shared address
    always_comb begin
        suppress_s = '0;
        lose_s     = '0;
        if ((ZERO_SUPPRESS != 0) && (mem_waddr[ADDR_W-1:0] == '0)) begin
            suppress_s[0] = 1'b1;
        end else begin
            suppress_s[0] = 1'b0;
        end
        cand_s = mem_we & {NUM_CH{mem_valid}} & ~suppress_s;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                lose_s[k] = lose_s[k] | ((SHARED_SPACE != 0) && (j > k) && cand_s[j] &&
                            (mem_waddr[j*ADDR_W +: ADDR_W] == mem_waddr[k*ADDR_W +: ADDR_W]));
            end
        end
        load_we_s = cand_s & ~lose_s;
    end

    // Counter increment that sticks at all-ones
    always_comb begin
        if (bubble_cnt_q == {CNT_W{1'b1}}) begin
            cnt_inc_s = bubble_cnt_q;
        end else begin
            cnt_inc_s = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Next-state selection: reset, flush, hold, bubble, load in priority order
    always_comb begin
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;
        we_d         = we_q;
        valid_d      = valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (rst) begin
            wdata_d      = '0;
            waddr_d      = '0;
            we_d         = '0;
            valid_d      = 1'b0;
            bubble_cnt_d = '0;
        end else if (flush || (stall_mem && !stall_wb)) begin
            wdata_d      = '0;
            waddr_d      = '0;
            we_d         = '0;
            valid_d      = 1'b0;
            bubble_cnt_d = cnt_inc_s;
        end else if (stall_wb) begin
            // WB stalled: everything, including a held bubble, stays as is
            wdata_d      = wdata_q;
            waddr_d      = waddr_q;
            we_d         = we_q;
            valid_d      = valid_q;
            bubble_cnt_d = bubble_cnt_q;
        end else begin
            wdata_d      = mem_wdata;
            waddr_d      = mem_waddr;
            we_d         = load_we_s;
            valid_d      = mem_valid;
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Pipeline state register
    always_ff @(posedge clk) begin
        wdata_q      <= wdata_d;
        waddr_q      <= waddr_d;
        we_q         <= we_d;
        valid_q      <= valid_d;
        bubble_cnt_q <= bubble_cnt_d;
    end

    assign wb_wdata   = wdata_q;
    assign wb_waddr   = waddr_q;
    assign wb_we      = we_q;
    assign wb_valid   = valid_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: two instances (private and shared register space, small counter)
// driven identically and checked every cycle against a per-channel behavioural model.
module tb_mem_wb_pipe;

    logic        clk;
    logic        rst, stall_mem, stall_wb, flush, mem_valid;
    logic [1:0]  in_we;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    logic [63:0] a_wdata, b_wdata;
    logic [9:0]  a_waddr, b_waddr;
    logic [1:0]  a_we, b_we;
    logic        a_valid, b_valid;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;

    // model state: index 0 = private-space DUT, 1 = shared-space DUT
    logic [31:0] m_d  [2][2];
    logic [4:0]  m_a  [2][2];
    bit          m_we [2][2];
    bit          m_v  [2];
    int          m_cnt[2];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    mem_wb_pipe dut_a (
        .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
        .mem_valid(mem_valid), .mem_wdata({d1, d0}), .mem_waddr({a1, a0}), .mem_we(in_we),
        .wb_wdata(a_wdata), .wb_waddr(a_waddr), .wb_we(a_we), .wb_valid(a_valid),
        .bubble_cnt(a_cnt)
    );

    mem_wb_pipe #(.SHARED_SPACE(1), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
        .mem_valid(mem_valid), .mem_wdata({d1, d0}), .mem_waddr({a1, a0}), .mem_we(in_we),
        .wb_wdata(b_wdata), .wb_waddr(b_waddr), .wb_we(b_we), .wb_valid(b_valid),
        .bubble_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the pipeline, expressed as "what WB must hold afterwards"
    task automatic model_step(input int d, input bit shared, input int cmax);
        bit [31:0] claimed;
        logic [31:0] din [2];
        logic [4:0]  ain [2];
        din[0] = d0; din[1] = d1;
        ain[0] = a0; ain[1] = a1;
        claimed = '0;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin m_d[d][k] = '0; m_a[d][k] = '0; m_we[d][k] = 1'b0; end
            m_v[d] = 1'b0;
            m_cnt[d] = 0;
        end else if (flush || (stall_mem && !stall_wb)) begin
            for (int k = 0; k < 2; k++) begin m_d[d][k] = '0; m_a[d][k] = '0; m_we[d][k] = 1'b0; end
            m_v[d] = 1'b0;
            if (m_cnt[d] < cmax) m_cnt[d] = m_cnt[d] + 1;
        end else if (!stall_wb) begin
            m_v[d] = mem_valid;
            // walk from the highest channel down; an address already written is taken
            for (int k = 1; k >= 0; k--) begin
                bit wants;
                m_d[d][k] = din[k];
                m_a[d][k] = ain[k];
                wants = in_we[k] && mem_valid && !(k == 0 && ain[k] == 5'd0);
                m_we[d][k] = wants && !(shared && claimed[ain[k]]);
                if (m_we[d][k]) claimed[ain[k]] = 1'b1;
            end
        end
    endtask

    task automatic step(input bit r, input bit sm, input bit sw, input bit fl, input bit v,
                        input logic [1:0] we, input logic [4:0] x0, input logic [31:0] y0,
                        input logic [4:0] x1, input logic [31:0] y1);
        rst = r; stall_mem = sm; stall_wb = sw; flush = fl; mem_valid = v;
        in_we = we; a0 = x0; d0 = y0; a1 = x1; d1 = y1;
        @(posedge clk);
        model_step(0, 1'b0, 65535);
        model_step(1, 1'b1, 7);
        #1;
    endtask

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a_wdata", a_wdata, {m_d[0][1], m_d[0][0]});
            cmp("a_waddr", a_waddr, {m_a[0][1], m_a[0][0]});
            cmp("a_we",    a_we,    {m_we[0][1], m_we[0][0]});
            cmp("a_valid", a_valid, m_v[0]);
            cmp("a_cnt",   a_cnt,   64'(m_cnt[0]));
            cmp("b_wdata", b_wdata, {m_d[1][1], m_d[1][0]});
            cmp("b_waddr", b_waddr, {m_a[1][1], m_a[1][0]});
            cmp("b_we",    b_we,    {m_we[1][1], m_we[1][0]});
            cmp("b_valid", b_valid, m_v[1]);
            cmp("b_cnt",   b_cnt,   64'(m_cnt[1]));
        end
    end

    initial begin
        // reset with every input active
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 5'd9, 32'hFFFF_FFFF, 5'd9, 32'h1234_5678);
        chk_en = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 5'd9, 32'hFFFF_FFFF, 5'd9, 32'h1234_5678);
        cmp("rst_wdata", a_wdata, 64'd0);
        cmp("rst_we",    a_we,    2'b00);
        cmp("rst_valid", a_valid, 1'b0);
        cmp("rst_cnt",   a_cnt,   16'd0);

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'd0);
        cmp("first_data",  a_wdata[31:0], 32'hDEAD_BEEF);
        cmp("first_addr",  a_waddr[4:0],  5'd3);
        cmp("first_we",    a_we,          2'b01);
        cmp("first_valid", a_valid,       1'b1);

        // pass-through stream
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 5'(i), 32'(i * 16), 5'd20, 32'h0000_00A5);
            cmp("pass_data0", a_wdata[31:0],  32'(i * 16));
            cmp("pass_addr0", a_waddr[4:0],   5'(i));
            cmp("pass_data1", a_wdata[63:32], 32'h0000_00A5);
            cmp("pass_we",    a_we,           2'b11);
            cmp("pass_cnt",   a_cnt,          16'd0);
        end

        // MEM stall -> bubbles
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 5'd6, 32'h1111_1111, 5'd7, 32'h2222_2222);
            cmp("bub_we",    a_we,    2'b00);
            cmp("bub_valid", a_valid, 1'b0);
        end
        cmp("bub_cnt", a_cnt, 16'd3);

        // WB stall dominates: frozen bubble, counter unchanged
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 5'd6, 32'h3333_3333, 5'd7, 32'h4444_4444);
            cmp("hold_valid", a_valid, 1'b0);
            cmp("hold_data",  a_wdata, 64'd0);
            cmp("hold_cnt",   a_cnt,   16'd3);
        end

        // flush beats stall_wb
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 5'd4, 32'h5555_5555, 5'd5, 32'h6666_6666);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 5'd4, 32'h7777_7777, 5'd5, 32'h8888_8888);
        cmp("flush_valid", a_valid, 1'b0);
        cmp("flush_we",    a_we,    2'b00);
        cmp("flush_cnt",   a_cnt,   16'd4);

        // zero-register suppression and shared-address arbitration
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 5'd0, 32'h9999_9999, 5'd5, 32'hAAAA_AAAA);
        cmp("zero_we", a_we, 2'b10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 5'd7, 32'hBBBB_BBBB, 5'd7, 32'hCCCC_CCCC);
        cmp("coll_priv_we",   a_we, 2'b11);
        cmp("coll_shared_we", b_we, 2'b10);

        // reset during a WB stall
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        cmp("rst_stall_we",  a_we,  2'b00);
        cmp("rst_stall_cnt", a_cnt, 16'd0);

        // saturation of the 3-bit counter
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 5'd3, 32'h3, 5'd4, 32'h4);
        cmp("sat_cnt_b", b_cnt, 3'd7);
        cmp("sat_cnt_a", a_cnt, 16'd10);

        // randomized traffic, narrow address range to provoke collisions and r0 writes
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, 2'($urandom),
                 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
